// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and fault cause codes.
// The trap unit decodes faultCause against these constants.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQUEST = 2'd1,
        FETCH_HOLD    = 2'd2,
        FETCH_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [1:0] FAULT_CAUSE_NONE       = 2'd0;
    localparam logic [1:0] FAULT_CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0] FAULT_CAUSE_BUS_ERROR  = 2'd2;
    localparam logic [1:0] FAULT_CAUSE_TIMEOUT    = 2'd3;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
interface instruction_fetch_unit_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic                     mem_request;
    logic [31:0]              mem_readData;
    logic                     mem_ack;
    logic                     mem_error;

    modport master (
        output mem_address, mem_request,
        input  mem_readData, mem_ack, mem_error
    );

    modport slave (
        input  mem_address, mem_request,
        output mem_readData, mem_ack, mem_error
    );
endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts cycles an instruction-bus request has been outstanding; expired marks the
// last cycle the request may stay unacknowledged.
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable && count != CW'(TIMEOUT_CYCLES))
            count <= count + 1'b1;
    end

    // Count is 0 in the first cycle the request is high, so TIMEOUT_CYCLES-1 is the last one.
    assign expired = count >= CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one word read per fetch address, result held for execute until consumed,
// with misaligned/bus-error/timeout faults and flush of stale results or in-flight reads.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] fetchAddress,
    input  logic                     fetchRequest,
    input  logic                     flush,
    input  logic                     instructionConsume,
    output logic [31:0]              instruction,
    output logic [ADDRESS_WIDTH-1:0] instructionAddress,
    output logic                     instructionValid,
    output logic                     fetchFault,
    output logic [1:0]               faultCause,
    instruction_fetch_unit_if.master bus
);
    fetch_state_t             state, state_next;
    logic [31:0]              instruction_next;
    logic [ADDRESS_WIDTH-1:0] instruction_address_next;
    logic                     valid_next, fault_next;
    logic [1:0]               cause_next;
    logic [ADDRESS_WIDTH-1:0] mem_address_next;
    logic                     mem_request_next;
    logic                     pending_valid, pending_valid_next;
    logic [ADDRESS_WIDTH-1:0] pending_address, pending_address_next;
    logic                     cand_valid;
    logic [ADDRESS_WIDTH-1:0] cand_address;
    logic                     issue, tmo_clear, tmo_expired;

    fetch_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (bus.mem_request),
        .expired (tmo_expired)
    );

    // A same-cycle fetchRequest beats the pending slot; flush kills an older pending address.
    assign cand_valid   = fetchRequest | (pending_valid & ~flush);
    assign cand_address = fetchRequest ? fetchAddress : pending_address;

    always_comb begin
        state_next               = state;
        instruction_next         = instruction;
        instruction_address_next = instructionAddress;
        valid_next               = instructionValid;
        fault_next               = fetchFault;
        cause_next               = faultCause;
        mem_address_next         = bus.mem_address;
        mem_request_next         = bus.mem_request;
        pending_valid_next       = pending_valid;
        pending_address_next     = pending_address;
        issue                    = 1'b0;
        tmo_clear                = 1'b0;

        if (fetchRequest) begin
            pending_valid_next   = 1'b1;
            pending_address_next = fetchAddress;
        end else if (flush) begin
            pending_valid_next   = 1'b0;
        end

        case (state)
            FETCH_IDLE: issue = cand_valid;
            FETCH_REQUEST: begin
                if (flush) begin
                    // An ack or timeout in the flush cycle ends the transfer as discarded.
                    if (bus.mem_ack || tmo_expired) begin
                        mem_request_next = 1'b0;
                        state_next       = FETCH_IDLE;
                        issue            = cand_valid;
                    end else begin
                        state_next       = FETCH_DISCARD;
                    end
                end else if (bus.mem_ack) begin
                    mem_request_next         = 1'b0;
                    state_next               = FETCH_HOLD;
                    instruction_address_next = bus.mem_address;
                    if (bus.mem_error) begin
                        fault_next = 1'b1;
                        cause_next = FAULT_CAUSE_BUS_ERROR;
                    end else begin
                        instruction_next = bus.mem_readData;
                        valid_next       = 1'b1;
                    end
                end else if (tmo_expired) begin
                    mem_request_next         = 1'b0;
                    state_next               = FETCH_HOLD;
                    instruction_address_next = bus.mem_address;
                    fault_next               = 1'b1;
                    cause_next               = FAULT_CAUSE_TIMEOUT;
                end
            end
            FETCH_HOLD: begin
                if (flush || instructionConsume) begin
                    valid_next = 1'b0;
                    fault_next = 1'b0;
                    cause_next = FAULT_CAUSE_NONE;
                    state_next = FETCH_IDLE;
                    issue      = cand_valid;
                end
            end
            FETCH_DISCARD: begin
                if (bus.mem_ack || tmo_expired) begin
                    mem_request_next = 1'b0;
                    state_next       = FETCH_IDLE;
                    issue            = cand_valid;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase

        // Start the next fetch with no idle cycle in between.
        if (issue) begin
            pending_valid_next = 1'b0;
            if (is_misaligned(cand_address[1:0])) begin
                state_next               = FETCH_HOLD;
                instruction_address_next = cand_address;
                valid_next               = 1'b0;
                fault_next               = 1'b1;
                cause_next               = FAULT_CAUSE_MISALIGNED;
            end else begin
                state_next       = FETCH_REQUEST;
                mem_address_next = cand_address;
                mem_request_next = 1'b1;
                tmo_clear        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= FETCH_IDLE;
            instruction        <= '0;
            instructionAddress <= '0;
            instructionValid   <= 1'b0;
            fetchFault         <= 1'b0;
            faultCause         <= FAULT_CAUSE_NONE;
            bus.mem_address    <= '0;
            bus.mem_request    <= 1'b0;
            pending_valid      <= 1'b0;
            pending_address    <= '0;
        end else begin
            state              <= state_next;
            instruction        <= instruction_next;
            instructionAddress <= instruction_address_next;
            instructionValid   <= valid_next;
            fetchFault         <= fault_next;
            faultCause         <= cause_next;
            bus.mem_address    <= mem_address_next;
            bus.mem_request    <= mem_request_next;
            pending_valid      <= pending_valid_next;
            pending_address    <= pending_address_next;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic checked
// every cycle against a transaction-level reference model.
module tb_instruction_fetch_unit;
    localparam int AW = 32;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] fetchAddress;
    logic          fetchRequest, flush, instructionConsume;
    logic [31:0]   instruction;
    logic [AW-1:0] instructionAddress;
    logic          instructionValid, fetchFault;
    logic [1:0]    faultCause;

    instruction_fetch_unit_if #(.ADDRESS_WIDTH(AW)) bus ();

    instruction_fetch_unit #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetchAddress       (fetchAddress),
        .fetchRequest       (fetchRequest),
        .flush              (flush),
        .instructionConsume (instructionConsume),
        .instruction        (instruction),
        .instructionAddress (instructionAddress),
        .instructionValid   (instructionValid),
        .fetchFault         (fetchFault),
        .faultCause         (faultCause),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a bus slot (busy/age/discard), a result slot, and a one-deep pending queue.
    bit          m_busy, m_discard, m_has, m_fault;
    int          m_age;
    logic [31:0] m_bus_addr, m_addr, m_data;
    logic [1:0]  m_cause;
    logic [31:0] m_pend[$];

    task automatic model_edge(input bit r, input bit fr, input logic [31:0] fa, input bit fl,
                              input bit cons, input bit ack, input bit err, input logic [31:0] data);
        bit          can_issue, cand_v;
        logic [31:0] cand;
        if (r) begin
            m_busy = 0; m_discard = 0; m_has = 0; m_fault = 0; m_cause = 0;
            m_pend.delete();
            return;
        end
        cand_v = fr || (!fl && m_pend.size() != 0);
        cand   = fr ? fa : (m_pend.size() != 0 ? m_pend[0] : 32'h0);
        if (fr) begin
            m_pend.delete();
            m_pend.push_back(fa);
        end else if (fl) begin
            m_pend.delete();
        end
        can_issue = 0;
        if (m_busy) begin
            if (ack || m_age == T) begin
                m_busy = 0;
                if (m_discard || fl) can_issue = 1;
                else begin
                    m_has  = 1;
                    m_addr = m_bus_addr;
                    if (ack && !err) begin
                        m_fault = 0; m_cause = 0; m_data = data;
                    end else begin
                        m_fault = 1; m_cause = ack ? 2'd2 : 2'd3;
                    end
                end
            end else begin
                m_age++;
                if (fl) m_discard = 1;
            end
        end else if (m_has) begin
            if (fl || cons) begin
                m_has = 0;
                can_issue = 1;
            end
        end else begin
            can_issue = 1;
        end
        if (can_issue && cand_v) begin
            m_pend.delete();
            if (cand[1:0] != 2'b00) begin
                m_has = 1; m_fault = 1; m_cause = 2'd1; m_addr = cand;
            end else begin
                m_busy = 1; m_age = 1; m_discard = 0; m_bus_addr = cand;
            end
        end
    endtask

    task automatic check_outputs();
        check("mem_request", 64'(bus.mem_request), 64'(m_busy));
        if (m_busy) check("mem_address", 64'(bus.mem_address), 64'(m_bus_addr));
        check("instructionValid", 64'(instructionValid), 64'(m_has && !m_fault));
        check("fetchFault", 64'(fetchFault), 64'(m_has && m_fault));
        check("faultCause", 64'(faultCause), m_has ? 64'(m_cause) : 64'd0);
        if (m_has) check("instructionAddress", 64'(instructionAddress), 64'(m_addr));
        if (m_has && !m_fault) check("instruction", 64'(instruction), 64'(m_data));
    endtask

    task automatic step(input bit r, input bit fr, input logic [31:0] fa, input bit fl,
                        input bit cons, input bit ack, input bit err, input logic [31:0] data);
        rst                = r;
        fetchRequest       = fr;
        fetchAddress       = fa;
        flush              = fl;
        instructionConsume = cons;
        bus.mem_ack        = ack;
        bus.mem_error      = err;
        bus.mem_readData   = data;
        @(posedge clk);
        model_edge(r, fr, fa, fl, cons, ack, err, data);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit          stall, r, fr, fl, cons, ack, err;
        logic [31:0] fa;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_instruction", 64'(instruction), 64'd0);
        check("rst_iaddr", 64'(instructionAddress), 64'd0);
        check("rst_mem_address", 64'(bus.mem_address), 64'd0);

        // 1: reset mid-request, late ack ignored
        step(0, 1, 32'h100, 0, 0, 0, 0, 0);
        check("t1_req_up", 64'(bus.mem_request), 64'd1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("t1_req_rst", 64'(bus.mem_request), 64'd0);
        check("t1_addr_rst", 64'(bus.mem_address), 64'd0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h55);
        check("t1_late_ack", 64'(instructionValid), 64'd0);

        // 2: zero-wait fetch, consume with back-to-back fetch
        step(0, 1, 32'h100, 0, 0, 0, 0, 0);
        check("t2_addr", 64'(bus.mem_address), 64'h100);
        step(0, 0, 0, 0, 0, 1, 0, 32'h13);
        check("t2_valid", 64'(instructionValid), 64'd1);
        check("t2_instr", 64'(instruction), 64'h13);
        check("t2_iaddr", 64'(instructionAddress), 64'h100);
        step(0, 1, 32'h104, 0, 1, 0, 0, 0);
        check("t2_next_req", 64'(bus.mem_request), 64'd1);
        check("t2_next_addr", 64'(bus.mem_address), 64'h104);
        step(0, 0, 0, 0, 0, 1, 0, 32'h00100093);
        step(0, 0, 0, 0, 1, 0, 0, 0);

        // 3: misaligned fault, no bus cycle
        step(0, 1, 32'h102, 0, 0, 0, 0, 0);
        check("t3_fault", 64'(fetchFault), 64'd1);
        check("t3_cause", 64'(faultCause), 64'd1);
        check("t3_no_req", 64'(bus.mem_request), 64'd0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("t3_cleared", 64'(fetchFault), 64'd0);

        // 4: flush of in-flight read, with and without a new fetch on the flush cycle
        step(0, 1, 32'h200, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        check("t4_no_valid", 64'(instructionValid), 64'd0);
        check("t4_idle", 64'(bus.mem_request), 64'd0);
        step(0, 1, 32'h200, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 32'h300, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        check("t4_reissue", 64'(bus.mem_request), 64'd1);
        check("t4_reissue_addr", 64'(bus.mem_address), 64'h300);
        check("t4_dropped", 64'(instructionValid), 64'd0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h11);
        step(0, 0, 0, 0, 1, 0, 0, 0);

        // 5: timeout after T unacked cycles, then bus error
        step(0, 1, 32'h400, 0, 0, 0, 0, 0);
        idle(T - 1);
        check("t5_still_req", 64'(bus.mem_request), 64'd1);
        idle(1);
        check("t5_req_drop", 64'(bus.mem_request), 64'd0);
        check("t5_cause", 64'(faultCause), 64'd3);
        step(0, 1, 32'h404, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h0);
        check("t5_buserr", 64'(faultCause), 64'd2);
        check("t5_buserr_valid", 64'(instructionValid), 64'd0);
        step(0, 0, 0, 0, 1, 0, 0, 0);

        // 6: newest pending address wins
        step(0, 1, 32'h500, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h77);
        step(0, 1, 32'h10, 0, 0, 0, 0, 0);
        step(0, 1, 32'h20, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("t6_addr", 64'(bus.mem_address), 64'h20);
        step(0, 0, 0, 0, 0, 1, 0, 32'h99);
        check("t6_iaddr", 64'(instructionAddress), 64'h20);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        check("t6_no_extra", 64'(bus.mem_request), 64'd0);

        // Random traffic
        stall = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) stall = ($urandom_range(0, 3) == 0);
            r    = ($urandom_range(0, 199) == 0);
            fr   = ($urandom_range(0, 3) == 0);
            fa   = $urandom();
            if ($urandom_range(0, 7) != 0) fa[1:0] = 2'b00;
            fl   = ($urandom_range(0, 11) == 0);
            cons = ($urandom_range(0, 2) == 0);
            ack  = m_busy && !stall && ($urandom_range(0, 2) == 0);
            err  = ($urandom_range(0, 4) == 0);
            step(r, fr, fa, fl, cons, ack, err, $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
